// File: rtl/gf2m_pkg.sv
// Shared constants, the xtime helper and the per-lane stage record for the
// pipelined GF(2^m) multiplier.
package gf2m_pkg;

    localparam int GF2M_WIDTH = 8;
    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int GF2M_MAX_W = 32;

    typedef logic [GF2M_MAX_W-1:0] gf_word_t;

    typedef struct packed {
        logic [GF2M_WIDTH-1:0] acc;
        logic [GF2M_WIDTH-1:0] s;
        logic [GF2M_WIDTH-1:0] b_rem;
    } gf2m_lane_t;

    // Multiply s by x modulo (x^width + poly); operands live in the low width bits.
    function automatic gf_word_t xtime(input gf_word_t s, input gf_word_t poly, input int width);
        gf_word_t mask;
        gf_word_t shifted;
        logic     msb;
        mask    = (gf_word_t'(1'b1) << width) - gf_word_t'(1'b1);
        msb     = |(s & (gf_word_t'(1'b1) << (width - 32'sd1)));
        shifted = {s[GF2M_MAX_W-2:0], 1'b0};
        if (msb) begin
            shifted = shifted ^ poly;
        end else begin
            shifted = shifted;
        end
        return shifted & mask;
    endfunction

endpackage

// File: rtl/gf2m_mult_pipe_if.sv
// Valid/ready bundle for the GF(2^m) multiplier: operand vectors in, product vectors out.
interface gf2m_mult_pipe_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_a;
    logic [LANES*WIDTH-1:0] in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/gf2m_mult_stage.sv
// One pipeline stage for all lanes: BPS LSB-first shift-and-add steps, then a
// register holding {acc, s, b_rem} per lane.
module gf2m_mult_stage
    import gf2m_pkg::*;
#(
    parameter int               WIDTH = GF2M_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY),
    parameter int               LANES = 4,
    parameter int               BPS   = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     load,
    input  logic [LANES*3*WIDTH-1:0] d,
    output logic [LANES*3*WIDTH-1:0] q
);

    typedef struct packed {
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] b_rem;
    } lane_t;

    lane_t [LANES-1:0] cur_s;
    lane_t [LANES-1:0] nxt_s;
    lane_t [LANES-1:0] q_r;

    assign cur_s = d;

    // Consume the low BPS coefficient bits of every lane.
    always_comb begin
        nxt_s = '0;
        for (int k = 0; k < LANES; k++) begin
            nxt_s[k] = cur_s[k];
            for (int i = 0; i < BPS; i++) begin
                if (cur_s[k].b_rem[i]) begin
                    nxt_s[k].acc = nxt_s[k].acc ^ nxt_s[k].s;
                end else begin
                    nxt_s[k].acc = nxt_s[k].acc;
                end
                nxt_s[k].s = WIDTH'(xtime(gf_word_t'(nxt_s[k].s), gf_word_t'(POLY), WIDTH));
            end
            nxt_s[k].b_rem = cur_s[k].b_rem >> BPS;
        end
    end

    // Stage register, written only when the handshake chain moves data in.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= nxt_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/gf2m_mult_pipe.sv
// Lane-parallel elastic GF(2^m) multiplier, STAGES deep, one vector per cycle.
// Optional GF2M_MULT_PERF_EN adds out_cnt/stall_cnt performance counters.
module gf2m_mult_pipe
    import gf2m_pkg::*;
#(
    parameter int               WIDTH  = GF2M_WIDTH,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(AES_POLY),
    parameter int               LANES  = 4,
    parameter int               STAGES = 2
) (
    input logic             clk,
    input logic             n_rst,
    gf2m_mult_pipe_if.slave bus
`ifdef GF2M_MULT_PERF_EN
    ,
    output logic [31:0]     out_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int BPS = WIDTH / STAGES;
    localparam int LW  = 3 * WIDTH;
    localparam int VW  = LANES * LW;

    if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
        $error("gf2m_mult_pipe: WIDTH must be a positive multiple of STAGES");
    end

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] open_s;
    logic [STAGES-1:0] take_s;
    logic [STAGES:0]   chain_s;
    logic [VW-1:0]     head_d_s;
    logic [VW-1:0]     stage_d_s [STAGES];
    logic [VW-1:0]     stage_q_s [STAGES];
    logic              unused_tail_s;

    assign chain_s = {valid_r, bus.in_valid};

    // Stall chain: a stage advances when it is full and its successor can take it.
    always_comb begin
        adv_s = '0;
        adv_s[STAGES-1] = valid_r[STAGES-1] & bus.out_ready;
        for (int j = STAGES - 2; j >= 0; j--) begin
            adv_s[j] = valid_r[j] & (~valid_r[j+1] | adv_s[j+1]);
        end
        open_s = ~valid_r | adv_s;
        take_s = open_s & chain_s[STAGES-1:0];
    end

    // Stage occupancy flags, shared by all lanes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_r <= '0;
        end else begin
            valid_r <= take_s | (~open_s & valid_r);
        end
    end

    assign bus.in_ready  = open_s[0];
    assign bus.out_valid = valid_r[STAGES-1];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign head_d_s[k*LW +: LW] = {{WIDTH{1'b0}}, bus.in_a[k*WIDTH +: WIDTH], bus.in_b[k*WIDTH +: WIDTH]};
        assign bus.out_p[k*WIDTH +: WIDTH] = stage_q_s[STAGES-1][k*LW + 2*WIDTH +: WIDTH];
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        if (j == 0) begin : g_head
            assign stage_d_s[j] = head_d_s;
        end else begin : g_body
            assign stage_d_s[j] = stage_q_s[j-1];
        end

        gf2m_mult_stage #(
            .WIDTH (WIDTH),
            .POLY  (POLY),
            .LANES (LANES),
            .BPS   (BPS)
        ) u_stage (
            .clk   (clk),
            .n_rst (n_rst),
            .load  (take_s[j]),
            .d     (stage_d_s[j]),
            .q     (stage_q_s[j])
        );
    end

    // Only acc leaves the last stage; its s/b_rem fields are dead.
    assign unused_tail_s = ^stage_q_s[STAGES-1];

`ifdef GF2M_MULT_PERF_EN
    // Output handshake and back-pressure counters, free-running with wrap.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_cnt   <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (valid_r[STAGES-1] && bus.out_ready) begin
                out_cnt <= out_cnt + 32'd1;
            end
            if (valid_r[STAGES-1] && !bus.out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gf2m_mult_pipe.sv
// Scoreboard bench for gf2m_mult_pipe: default 8-bit/4-lane/2-stage build plus
// a 4-bit/1-lane/4-stage instance; perf counters checked when GF2M_MULT_PERF_EN is set.
module tb_gf2m_mult_pipe;

    localparam int W = 8;
    localparam int L = 4;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    gf2m_mult_pipe_if #(.LANES(L), .WIDTH(W)) bus ();
    gf2m_mult_pipe_if #(.LANES(1), .WIDTH(4)) bus4 ();

`ifdef GF2M_MULT_PERF_EN
    logic [31:0] out_cnt, stall_cnt, out_cnt4, stall_cnt4;
`endif

    gf2m_mult_pipe #(.WIDTH(8), .POLY(8'h1B), .LANES(4), .STAGES(2)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus)
`ifdef GF2M_MULT_PERF_EN
        ,
        .out_cnt   (out_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    gf2m_mult_pipe #(.WIDTH(4), .POLY(4'h3), .LANES(1), .STAGES(4)) dut4 (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus4)
`ifdef GF2M_MULT_PERF_EN
        ,
        .out_cnt   (out_cnt4),
        .stall_cnt (stall_cnt4)
`endif
    );

    int tests = 0;
    int fails = 0;
    int n_out = 0;
    logic [L*W-1:0] exp_q [$];
    logic [L*W-1:0] exp_v;

    // Schoolbook carry-less product followed by top-down polynomial reduction.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                           input int w, input logic [7:0] poly);
        logic [15:0] prod;
        logic [15:0] red;
        prod = 16'd0;
        red  = (16'd1 << w) | {8'd0, poly};
        for (int i = 0; i < w; i++) begin
            if (b[i]) prod = prod ^ ({8'd0, a} << i);
        end
        for (int i = 2 * w - 2; i >= w; i--) begin
            if (prod[i]) prod = prod ^ (red << (i - w));
        end
        return prod[7:0];
    endfunction

    function automatic logic [L*W-1:0] ref_vec(input logic [L*W-1:0] a, input logic [L*W-1:0] b);
        logic [L*W-1:0] r;
        r = '0;
        for (int k = 0; k < L; k++) begin
            r[k*W +: W] = ref_mul(a[k*W +: W], b[k*W +: W], W, 8'h1B);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a vector and hold it until the edge that transfers it.
    task automatic send(input logic [L*W-1:0] a, input logic [L*W-1:0] b);
        int budget;
        budget = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        #1;
        while (!bus.in_ready && budget < 50) begin
            tick();
            #1;
            budget++;
        end
        check("send_timeout", 64'(budget < 50), 64'd1);
        tick();
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            tick();
            budget++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic w4_run(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r8;
        r8 = ref_mul({4'd0, a}, {4'd0, b}, 4, 8'h03);
        bus4.in_valid = 1'b1;
        bus4.in_a     = a;
        bus4.in_b     = b;
        #1;
        check("w4_in_ready", 64'(bus4.in_ready), 64'd1);
        tick();
        bus4.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("w4_latency_gap", 64'(bus4.out_valid), 64'd0);
            tick();
        end
        check("w4_out_valid", 64'(bus4.out_valid), 64'd1);
        check("w4_out_p", 64'(bus4.out_p), 64'(r8));
        tick();
        check("w4_single_beat", 64'(bus4.out_valid), 64'd0);
    endtask

    // Scoreboard: pop and compare on output handshakes, push on input handshakes.
    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL stale_output: observed out_p 0x%0h with no pending vector, expected none", bus.out_p);
                end
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    tests++;
                    assert (bus.out_p === exp_v) else begin
                        fails++;
                        $error("FAIL sb_out_p: observed 0x%0h, expected 0x%0h", bus.out_p, exp_v);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_vec(bus.in_a, bus.in_b));
            end
        end
    end

    initial begin
        logic [L*W-1:0] held;
        int             out_base;

        n_rst          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_a      = '0;
        bus4.in_b      = '0;
        bus4.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_p", 64'(bus.out_p), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        #2;
        n_rst = 1'b1;
        #1;
        check("rst_rel_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_rel_w4_valid", 64'(bus4.out_valid), 64'd0);
        tick();

        // Single vector, latency of two edges, one-beat output
        bus.in_valid = 1'b1;
        bus.in_a     = {8'h00, 8'h00, 8'h00, 8'h57};
        bus.in_b     = {8'h00, 8'h00, 8'h00, 8'h83};
        #1;
        check("single_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("single_gap", 64'(bus.out_valid), 64'd0);
        tick();
        check("single_out_valid", 64'(bus.out_valid), 64'd1);
        check("single_lane0", 64'(bus.out_p[7:0]), 64'h0C1);
        tick();
        check("single_one_beat", 64'(bus.out_valid), 64'd0);

        // Per-lane boundary patterns: reduction, zero operand, identity coefficient
        send({8'hA5, 8'h00, 8'h02, 8'h57}, {8'h01, 8'hFF, 8'h87, 8'h13});
        bus.in_valid = 1'b0;
        tick();
        check("lanes_out_valid", 64'(bus.out_valid), 64'd1);
        check("lanes_out_p", 64'(bus.out_p), 64'(32'hA50015FE));
        drain();

        // Back-pressure: fill, hold for five stalled cycles, then release
        bus.out_ready = 1'b0;
        send(32'h8A3C01FF, 32'h0B0D0E09);
        send(32'h12345678, 32'h9ABCDEF0);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hDEADBEEF;
        bus.in_b     = 32'h0E0D0B09;
        #1;
        held = bus.out_p;
        check("stall_head", 64'(held), 64'(ref_vec(32'h8A3C01FF, 32'h0B0D0E09)));
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_out_p_hold", 64'(bus.out_p), 64'(held));
            tick();
        end
`ifdef GF2M_MULT_PERF_EN
        check("perf_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
        bus.out_ready = 1'b1;
        send(32'hDEADBEEF, 32'h0E0D0B09);
        send(32'hFFFFFFFF, 32'hFFFFFFFF);
        bus.in_valid = 1'b0;
        drain();

        // Streaming: one vector per cycle with out_ready held high
        out_base = n_out;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            #1;
            check("stream_in_ready", 64'(bus.in_ready), 64'd1);
            if (i >= 2) check("stream_out_valid", 64'(bus.out_valid), 64'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        drain();
        check("stream_count", 64'(n_out - out_base), 64'd100);
`ifdef GF2M_MULT_PERF_EN
        check("perf_out_cnt", 64'(out_cnt), 64'(n_out));
`endif

        // Reset with two vectors in flight
        bus.out_ready = 1'b0;
        send(32'h80808080, 32'h80808080);
        send(32'h01020304, 32'h05060708);
        bus.in_valid = 1'b0;
        check("midrst_pre_valid", 64'(bus.out_valid), 64'd1);
        n_rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_p", 64'(bus.out_p), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        bus.out_ready = 1'b1;
        #2;
        n_rst = 1'b1;
`ifdef GF2M_MULT_PERF_EN
        #1;
        check("midrst_out_cnt", 64'(out_cnt), 64'd0);
        check("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_stale", 64'(bus.out_valid), 64'd0);
        end
        send(32'h57575757, 32'h83138701);
        bus.in_valid = 1'b0;
        drain();

        // Narrow field, four-stage latency
        w4_run(4'h7, 4'h9);
        w4_run(4'h8, 4'hF);
        w4_run(4'hB, 4'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
